// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin word arbiter: select-width sizing and the
// rotating-priority search used to pick the next granted source.
package rr_arb_pkg;

  localparam int unsigned REQ_MAX   = 64;
  localparam int unsigned REQ_IDX_W = 6;

  // Width of the select register; never below one bit so WIDTH=1 still has a flop.
  function automatic int unsigned sel_bits(input int unsigned width);
    return (width > 1) ? 32'($clog2(width)) : 32'd1;
  endfunction

  // First requester after sel, wrapping around, with sel itself tried last.
  // With no requester at all the current selection is kept.
  function automatic int unsigned next_req(input int unsigned       width,
                                           input int unsigned       sel,
                                           input logic [REQ_MAX-1:0] req);
    int unsigned idx;
    next_req = sel;
    for (int unsigned k = width; k >= 1; k--) begin
      idx = (sel + k) % width;
      if (req[idx[REQ_IDX_W-1:0]]) next_req = idx;
    end
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational rotating priority encoder: next source to grant after sel.
module rr_next_sel
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned SEL_W = 1
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] req,
  output logic [SEL_W-1:0] next_sel_c
);

  logic [REQ_MAX-1:0] req_ext;

  assign req_ext = REQ_MAX'(req);

  always_comb begin
    next_sel_c = SEL_W'(next_req(WIDTH, 32'(sel), req_ext));
  end

endmodule

// File: rtl/rr_word_arbiter.sv
// Round-robin N-to-1 word arbiter merging FWFT source FIFOs into one sink FIFO.
// Define RR_ARB_HOLD_EN to let a source keep the grant across words via HOLD_REQ.
module rr_word_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0]            READ_GRANT,
  input  logic                        READY_OUT,
  output logic                        WRITE_OUT,
  output logic [DATA_WIDTH-1:0]       DATA_OUT
);

  localparam int unsigned SEL_W = sel_bits(WIDTH);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] next_sel_c;
  logic             req_sel_c;
  logic             xfer_c;
  logic             hold_c;

  rr_next_sel #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_next_sel (
    .sel        (sel_q),
    .req        (WRITE_REQ),
    .next_sel_c (next_sel_c)
  );

`ifdef RR_ARB_HOLD_EN
  assign hold_c = HOLD_REQ[sel_q];
`else
  logic unused_hold_req;
  assign unused_hold_req = ^HOLD_REQ;
  assign hold_c          = 1'b0;
`endif

  assign req_sel_c = WRITE_REQ[sel_q];
  assign xfer_c    = req_sel_c & READY_OUT;

  // Move on after a delivered word or away from an idle source, unless held.
  always_comb begin
    sel_d = sel_q;
    if (!hold_c && (xfer_c || !req_sel_c)) begin
      sel_d = next_sel_c;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q <= SEL_W'(WIDTH - 1);
    end else begin
      sel_q <= sel_d;
    end
  end

  // Zero-latency sink/source interface, forced quiet while reset is asserted.
  always_comb begin
    WRITE_OUT  = 1'b0;
    DATA_OUT   = '0;
    READ_GRANT = '0;
    if (RST_N) begin
      WRITE_OUT = req_sel_c;
      DATA_OUT  = DATA_IN[sel_q*DATA_WIDTH +: DATA_WIDTH];
      if (xfer_c) READ_GRANT[sel_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_word_arbiter.sv
// Scoreboard bench for rr_word_arbiter: bench-side source FIFOs, random sink
// back-pressure, and a queue-based round-robin reference model.
module tb_rr_word_arbiter;

  localparam int unsigned W  = 2;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [W-1:0]  grant;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    write_req = '0;
  logic [W-1:0]    hold_req = '0;
  logic [W*DW-1:0] data_in = '0;
  logic [W-1:0]    read_grant;
  logic            ready_out = 1'b0;
  logic            write_out;
  logic [DW-1:0]   data_out;

  logic [DW-1:0] src_q [W][$];
  int            seq [W];
  exp_t          exp_q [$];
  logic          wq [$];
  int            cur = W - 1;
  int            errors = 0;
  int            checks = 0;

  rr_word_arbiter #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .WRITE_REQ  (write_req),
    .HOLD_REQ   (hold_req),
    .DATA_IN    (data_in),
    .READ_GRANT (read_grant),
    .READY_OUT  (ready_out),
    .WRITE_OUT  (write_out),
    .DATA_OUT   (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [W-1:0] v, input int i);
    return ((v >> i) & W'(1)) != '0;
  endfunction

  // One clock of stimulus: refill sources, drive FWFT heads, predict the outcome.
  task automatic cycle(input logic [W-1:0] fill, input logic rdy,
                       input logic [W-1:0] hold, input bit do_rst);
    logic [W-1:0]    req;
    logic [W*DW-1:0] din;
    logic            w;
    logic            h;
    int              nxt;
    exp_t            e;
    @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      if (fill[i]) begin
        src_q[i].push_back(DW'((i + 1) << 24) | DW'(seq[i]));
        seq[i]++;
      end
    end
    req = '0;
    din = '0;
    for (int i = 0; i < W; i++) begin
      if (src_q[i].size() > 0) begin
        req[i] = 1'b1;
        din[i*DW +: DW] = src_q[i][0];
      end
    end
    write_req = req;
    data_in   = din;
    ready_out = rdy;
    hold_req  = hold;
    if (do_rst) begin
      rst_n = 1'b0;
      cur   = W - 1;
    end else begin
      rst_n = 1'b1;
      w = bit_at(req, cur);
      wq.push_back(w);
      if (w && rdy) begin
        e.data  = src_q[cur][0];
        e.grant = W'(1) << cur;
        exp_q.push_back(e);
        void'(src_q[cur].pop_front());
      end
`ifdef RR_ARB_HOLD_EN
      h = bit_at(hold, cur);
`else
      h = 1'b0;
`endif
      if (!h && (!w || rdy)) begin
        nxt = cur;
        for (int k = W; k >= 1; k--) begin
          if (bit_at(req, (cur + k) % W)) nxt = (cur + k) % W;
        end
        cur = nxt;
      end
    end
  endtask

  // Monitor: outputs quiet in reset; otherwise compare valid and each transfer.
  always @(negedge clk) begin
    logic ew;
    exp_t e;
    if (!rst_n) begin
      checks++;
      if (write_out !== 1'b0 || read_grant !== '0 || data_out !== '0) begin
        errors++;
        $display("FAIL reset_quiet: write_out=%b read_grant=%b data_out=%h, required 0/0/0",
                 write_out, read_grant, data_out);
      end
    end else if (wq.size() > 0) begin
      ew = wq.pop_front();
      checks++;
      if (write_out !== ew) begin
        errors++;
        $display("FAIL write_out: got %b, required %b at %0t", write_out, ew, $time);
      end
      if (write_out === 1'b1 && ready_out === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: data_out=%h read_grant=%b, required no transfer",
                   data_out, read_grant);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.data || read_grant !== e.grant) begin
            errors++;
            $display("FAIL xfer_word: data_out=%h read_grant=%b, required %h/%b at %0t",
                     data_out, read_grant, e.data, e.grant, $time);
          end
        end
      end else begin
        checks++;
        if (read_grant !== '0) begin
          errors++;
          $display("FAIL idle_grant: read_grant=%b, required 00 at %0t", read_grant, $time);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < W; i++) seq[i] = 0;
    // Reset with no requests, then with requests pending.
    cycle('0, 1'b1, '0, 1'b1);
    cycle('0, 1'b1, '0, 1'b1);
    cycle('1, 1'b1, '0, 1'b1);
    // Both sources busy at full sink rate.
    for (int n = 0; n < 8; n++) cycle('1, 1'b1, '0, 1'b0);
    for (int n = 0; n < 40 && (src_q[0].size() + src_q[1].size()) > 0; n++)
      cycle('0, 1'b1, '0, 1'b0);
    // Only source 1 active.
    for (int n = 0; n < 6; n++) cycle(W'(2), 1'b1, '0, 1'b0);
    // Back-pressure with both requesting, then release.
    for (int n = 0; n < 4; n++) cycle('1, 1'b0, '0, 1'b0);
    for (int n = 0; n < 4; n++) cycle('1, 1'b1, '0, 1'b0);
    // Source 0 asks to hold, then drops it.
    for (int n = 0; n < 6; n++) cycle('1, 1'b1, W'(1), 1'b0);
    for (int n = 0; n < 4; n++) cycle('1, 1'b1, '0, 1'b0);
    // Reset asserted in the middle of traffic.
    cycle('1, 1'b1, '0, 1'b1);
    for (int n = 0; n < 4; n++) cycle('1, 1'b1, '0, 1'b0);
    // Randomised traffic, back-pressure and hold requests.
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] f;
      logic [W-1:0] hd;
      for (int i = 0; i < W; i++) begin
        f[i]  = ($urandom_range(0, 99) < 45);
        hd[i] = ($urandom_range(0, 99) < 20);
      end
      cycle(f, $urandom_range(0, 99) < 75, hd, 1'b0);
    end
    for (int n = 0; n < 100 && (src_q[0].size() + src_q[1].size()) > 0; n++)
      cycle('0, 1'b1, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words and %0d cycles unmatched, required 0/0",
               exp_q.size(), wq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
